// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave backed by a word-organised RAM, with configurable wait states
// and a two-cycle ERROR response. Optional macro AHB_SRAM_SLAVE_ALIGN_CHECK_EN flags misaligned transfers.
`timescale 1ns/1ps
`default_nettype none

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef HSIZE_8
`define HSIZE_8 3'b000
`endif
`ifndef HSIZE_16
`define HSIZE_16 3'b001
`endif
`ifndef HSIZE_32
`define HSIZE_32 3'b010
`endif
`ifndef HRESP_OKAY
`define HRESP_OKAY 2'b00
`endif
`ifndef HRESP_ERROR
`define HRESP_ERROR 2'b01
`endif

module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     HSEL,
  input  logic [`WORD_WIDTH-1:0]   HADDR,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [2:0]               HBURST,
  input  logic [1:0]               HTRANS,
  input  logic                     HMASTLOCK,
  input  logic [`WORD_WIDTH-1:0]   HWDATA,
  input  logic                     HREADY,
  output logic                     HREADYOUT,
  output logic [1:0]               HRESP,
  output logic [`WORD_WIDTH-1:0]   HRDATA
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_MASK  = ~((32'(DEPTH_WORDS) << 2) - 32'd1);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  state_t          accept_target;
  logic [AW-1:0]   idx;
  logic            wr;
  logic [2:0]      size;
  logic [1:0]      lo;
  logic [3:0]      wcnt;
  logic [3:0]      be;
  logic            accept;
  logic            in_range;
  logic            size_ok;
  logic            align_ok;
  logic            req_err;
  logic            unused_ok;

  logic [31:0] mem [DEPTH_WORDS];

  assign unused_ok = ^{HBURST, HMASTLOCK, HTRANS[0]};

  // New address phases are only taken when the previous data phase is completing.
  assign accept = HSEL && HREADY && HTRANS[1] &&
                  ((state == S_IDLE) || (state == S_DATA) || (state == S_ERR2));

  assign in_range = ((HADDR & WIN_MASK) == BASE_ADDR);

  always_comb begin
    size_ok = 1'b0;
    case (HSIZE)
      `HSIZE_8, `HSIZE_16, `HSIZE_32: size_ok = 1'b1;
      default:                        size_ok = 1'b0;
    endcase
  end

`ifdef AHB_SRAM_SLAVE_ALIGN_CHECK_EN
  always_comb begin
    align_ok = 1'b1;
    if ((HSIZE == `HSIZE_16) && HADDR[0])
      align_ok = 1'b0;
    if ((HSIZE == `HSIZE_32) && (HADDR[1:0] != 2'b00))
      align_ok = 1'b0;
  end
`else
  assign align_ok = 1'b1;
`endif

  assign req_err = !in_range || !size_ok || !align_ok;

  always_comb begin
    accept_target = S_DATA;
    if (req_err)
      accept_target = S_ERR1;
    else if (WAIT_CYCLES > 0)
      accept_target = S_WAIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DATA, S_ERR2: state_nxt = accept ? accept_target : S_IDLE;
      S_WAIT:                 if (wcnt <= 4'd1) state_nxt = S_DATA;
      S_ERR1:                 state_nxt = S_ERR2;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Kept separate from next-state so HREADYOUT never depends on HREADY combinationally.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = `HRESP_OKAY;
    case (state)
      S_WAIT:  HREADYOUT = 1'b0;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = `HRESP_ERROR;
      end
      S_ERR2:  HRESP = `HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      wr   <= 1'b0;
      size <= `HSIZE_32;
      lo   <= 2'b00;
      wcnt <= 4'd0;
    end else if (accept) begin
      idx  <= HADDR[AW+1:2];
      wr   <= HWRITE;
      size <= HSIZE;
      lo   <= HADDR[1:0];
      wcnt <= WAIT_INIT;
    end else if ((state == S_WAIT) && (wcnt != 4'd0)) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // Lane selection ignores misaligned low bits; misalignment is rejected at accept when checking is on.
  always_comb begin
    be = 4'b0000;
    case (size)
      `HSIZE_8:  be = 4'b0001 << lo;
      `HSIZE_16: be = lo[1] ? 4'b1100 : 4'b0011;
      `HSIZE_32: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
  end

  // Commit at the edge closing DATA so a back-to-back load of the same word sees the new value.
  always_ff @(posedge clk) begin
    if ((state == S_DATA) && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[idx][i*8 +: 8] <= HWDATA[i*8 +: 8];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if ((state == S_DATA) && !wr)
      HRDATA = mem[idx];
  end

endmodule

`default_nettype wire
